// File: rtl/rr_dff_arbiter.sv
// rr_dff_arbiter: round-robin arbiter feeding a single registered output slot.
// NREQ requesters compete for one DW-bit register stage. Round-robin priority
// starts just after the last winner. A full slot can be drained and reloaded
// on the same edge, so the stage runs at full throughput.
//
// Handshake: a transfer happens on any edge where valid & ready are both high.
// Valid never depends on ready. On the request side, req_ready is one-hot or
// zero. It depends combinationally on out_ready. It is forced low while rst is
// high, so no handshake completes during reset.
module rr_dff_arbiter #(
    parameter  int NREQ = 4,
    parameter  int DW   = 32,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_mask,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [IW-1:0]        out_src,
    input  logic                 out_ready
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IW-1:0]     rr_ptr;
    logic [DW-1:0]     data_q;
    logic [IW-1:0]     src_q;

    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   grant;
    logic              found;
    logic [IW-1:0]     grant_idx;
    logic [DW-1:0]     grant_data;
    logic              can_load;
    logic              load;

    assign elig = req_valid & req_mask;

    // Round-robin search: first eligible requester after rr_ptr, wrapping to 0.
    always_comb begin
        int cand;
        cand       = 0;
        grant      = '0;
        found      = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(rr_ptr) + k) % NREQ;
            if (!found && elig[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IW'(cand);
                grant_data  = req_data[cand*DW +: DW];
            end
        end
    end

    // State register: EMPTY/FULL occupancy of the output slot.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_EMPTY;
        else     state_q <= state_d;
    end

    // Next state: a load always leaves the slot full; a drain without a load empties it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (load) state_d = S_FULL;
            S_FULL:  if (out_ready && !load) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    // Outputs: slot may load when empty or being drained this cycle (bypass on drain).
    always_comb begin
        out_valid = (state_q == S_FULL);
        can_load  = !out_valid || out_ready;
        req_ready = (can_load && !rst) ? grant : '0;
        load      = can_load && found && !rst;
    end

    // Slot data, source index and round-robin pointer; all move only on a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            src_q  <= '0;
            rr_ptr <= IW'(NREQ - 1);
        end else if (load) begin
            data_q <= grant_data;
            src_q  <= grant_idx;
            rr_ptr <= grant_idx;
        end
    end

    assign out_data = data_q;
    assign out_src  = src_q;

endmodule

// File: tb/tb_rr_dff_arbiter.sv
// tb_rr_dff_arbiter: directed scenarios plus a random phase for rr_dff_arbiter.
// A reference model predicts grants. Accepted beats are queued as {src,data}
// and popped when the slot drains.
module tb_rr_dff_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IW   = $clog2(NREQ);
    localparam int SW   = IW + DW;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_mask;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic [IW-1:0]        out_src;
    logic                 out_ready;

    logic [DW-1:0]        dat [NREQ];

    int n_tests = 0;
    int n_fail  = 0;

    logic [SW-1:0] exp_q[$];
    logic          mon_en = 1'b0;
    logic          m_valid = 1'b0;
    int            m_ptr = NREQ - 1;

    rr_dff_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_mask  (req_mask),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = dat[i];
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] e, input int ptr);
        for (int k = 1; k <= NREQ; k++) begin
            if (e[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // ---------------- scoreboard monitor (negedge, inputs stable) ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            logic             can_ld;
            logic             drain;
            int               g;
            logic [NREQ-1:0]  exp_rdy;
            logic [SW-1:0]    front;
            can_ld  = !m_valid || out_ready;
            g       = pick(req_valid & req_mask, m_ptr);
            exp_rdy = '0;
            if (can_ld && !rst && g >= 0) exp_rdy[g] = 1'b1;
            check("sb_out_valid", 64'(out_valid), 64'(m_valid));
            check("sb_req_ready", 64'(req_ready), 64'(exp_rdy));
            if (rst) begin
                m_valid = 1'b0;
                m_ptr   = NREQ - 1;
                exp_q.delete();
            end else begin
                drain = m_valid && out_ready;
                if (drain) begin
                    if (exp_q.size() == 0) begin
                        check("sb_queue_empty", 64'(exp_q.size()), 64'd1);
                    end else begin
                        front = exp_q.pop_front();
                        check("sb_out_src", 64'(out_src), 64'(front[SW-1:DW]));
                        check("sb_out_data", 64'(out_data), 64'(front[DW-1:0]));
                    end
                end
                if (can_ld && g >= 0) begin
                    exp_q.push_back({IW'(g), dat[g]});
                    m_ptr   = g;
                    m_valid = 1'b1;
                end else if (drain) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rand_data();
        for (int i = 0; i < NREQ; i++) dat[i] = $urandom;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst       = 1'b1;
        req_mask  = 4'hF;
        req_valid = 4'hF;
        out_ready = 1'b0;
        set_rand_data();

        // Reset held 2 cycles with all requesters valid.
        tick();
        mon_en = 1'b1;
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_src",   64'(out_src),   64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);

        // Round-robin fairness, all valid, consumer always ready.
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rr_first_ready", 64'(req_ready), 64'b0001);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr_out_valid", 64'(out_valid), 64'd1);
            check("rr_out_src",   64'(out_src),   64'(i % NREQ));
            check("rr_out_data",  64'(out_data),  64'(dat[i % NREQ]));
        end

        // Backpressure: load 0xA5 from req 0, then stall the consumer.
        dat[0] = 32'hA5;
        tick();
        check("bp_load_src",  64'(out_src),  64'd0);
        check("bp_load_data", 64'(out_data), 64'hA5);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dat[0] = $urandom;
            tick();
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data",  64'(out_data),  64'hA5);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(req_ready), 64'b0010);
        tick();
        check("bp_nobubble_valid", 64'(out_valid), 64'd1);
        check("bp_nobubble_src",   64'(out_src),   64'd1);

        // Mask 1010: only requesters 1 and 3 may win, alternating.
        req_mask = 4'b1010;
        #1;
        check("mask_ready", 64'(req_ready), 64'b1000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mask_src",        64'(out_src), 64'((i % 2 == 0) ? 3 : 1));
            check("mask_ready_0_2",  64'(req_ready & 4'b0101), 64'd0);
        end

        // Sparse/wrap: only req 3, then only req 0.
        req_mask  = 4'hF;
        req_valid = 4'b1000;
        tick();
        check("wrap_src3",   64'(out_src),   64'd3);
        check("wrap_valid3", 64'(out_valid), 64'd1);
        req_valid = 4'b0001;
        tick();
        check("wrap_src0",   64'(out_src),   64'd0);
        check("wrap_valid0", 64'(out_valid), 64'd1);
        req_valid = 4'b0000;
        tick();
        check("wrap_drained", 64'(out_valid), 64'd0);

        // Masked sole requester is never granted.
        req_mask  = 4'b1110;
        req_valid = 4'b0001;
        #1;
        check("mask_sole_ready", 64'(req_ready), 64'd0);
        tick();
        check("mask_sole_valid", 64'(out_valid), 64'd0);

        // Reset mid-operation with a full, stalled slot.
        req_mask  = 4'hF;
        req_valid = 4'hF;
        out_ready = 1'b0;
        tick();
        check("midrst_full", 64'(out_valid), 64'd1);
        check("midrst_src",  64'(out_src),   64'd1);
        rst = 1'b1;
        tick();
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_src0",  64'(out_src),   64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("midrst_first_ready", 64'(req_ready), 64'b0001);
        tick();
        check("midrst_first_src", 64'(out_src), 64'd0);

        // Random phase: scoreboard monitor checks every cycle.
        for (int i = 0; i < 300; i++) begin
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            req_mask  = ($urandom_range(0, 3) == 0) ? NREQ'($urandom_range(0, (1 << NREQ) - 1)) : 4'hF;
            out_ready = ($urandom_range(0, 3) != 0);
            set_rand_data();
            tick();
        end

        // Drain and confirm nothing is left outstanding.
        req_valid = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_out_valid",   64'(out_valid),    64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
